// File: rtl/step_sequencer_pkg.sv
// Shared sequencer state encoding and stage index constants.
// Imported by the step sequencer and anything that decodes its stage.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT_MEM,
    HALTED,
    ERROR
  } seq_state_t;

  localparam int STG_FETCH = 0;
  localparam int STG_MEM   = 3;

endpackage

// File: rtl/step_sequencer_if.sv
// Memory handshake between the sequencer and the datapath/memory.
// master = sequencer side, slave = datapath/memory side.
interface step_sequencer_if;

  logic mem_need;
  logic mem_ready;
  logic mem_req;

  modport master (
    input  mem_need,
    input  mem_ready,
    output mem_req
  );

  modport slave (
    output mem_need,
    output mem_ready,
    input  mem_req
  );

endinterface

// File: rtl/step_sequencer_step_sync.sv
// Step button synchroniser with rising-edge detect.
// One press yields a single one-cycle token.
module step_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic token
);

  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[1:0], btn};
    end
  end

  assign token = sync[1] & ~sync[2];

endmodule

// File: rtl/step_sequencer.sv
// Instruction stage sequencer: free-run or single-step, with
// memory wait states, timeout error and halt-after-instruction.
module step_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter logic [NUM_STAGES-1:0] MEM_STAGE_MASK = 5'b01001,
  parameter int AUTO_DIV = 0,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 16,
  localparam int STG_W = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  is_auto,
  input  logic                  next_stage,
  input  logic                  halt_req,
  step_sequencer_if.master      mem,
  output logic [STG_W-1:0]      stage,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  halted,
  output logic                  error,
  output logic [CNT_W-1:0]      instr_count
);

  localparam int PRE_W  = $clog2(AUTO_DIV + 2);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [STG_W-1:0] LAST = STG_W'(NUM_STAGES - 1);

  seq_state_t            state, state_n;
  logic [STG_W-1:0]      stage_n;
  logic [NUM_STAGES-1:0] en_n;
  logic [CNT_W-1:0]      cnt_n;
  logic [PRE_W-1:0]      pre, pre_n;
  logic [WAIT_W-1:0]     wait_cnt, wait_n;
  logic req, req_n;
  logic halted_n, error_n;
  logic hold, hold_n;
  logic auto_q;
  logic token, adv, commit;

  step_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (next_stage),
    .token (token)
  );

  assign adv = (state == RUN) &&
               (is_auto ? (pre == PRE_W'(AUTO_DIV)) : token);

  always_comb begin
    state_n  = state;
    stage_n  = stage;
    en_n     = '0;
    req_n    = req;
    halted_n = halted;
    error_n  = error;
    cnt_n    = instr_count;
    hold_n   = hold | halt_req;
    wait_n   = wait_cnt;
    pre_n    = pre;
    commit   = 1'b0;

    // A mode change restarts the prescaler so auto timing is fresh.
    if (is_auto != auto_q) begin
      pre_n = '0;
    end else if (state == RUN && is_auto) begin
      pre_n = adv ? '0 : pre + 1'b1;
    end

    unique case (state)
      IDLE: state_n = RUN;
      RUN: begin
        if (adv) begin
          if (MEM_STAGE_MASK[stage] && mem.mem_need) begin
            state_n = WAIT_MEM;
            req_n   = 1'b1;
            wait_n  = '0;
          end else begin
            commit = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (mem.mem_ready) begin
          req_n  = 1'b0;
          commit = 1'b1;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_n = ERROR;
          req_n   = 1'b0;
          error_n = 1'b1;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      default: ;
    endcase

    if (commit) begin
      en_n = NUM_STAGES'(1) << stage;
      if (stage == LAST) begin
        stage_n  = STG_W'(STG_FETCH);
        cnt_n    = instr_count + 1'b1;
        state_n  = hold_n ? HALTED : RUN;
        halted_n = hold_n;
      end else begin
        stage_n = stage + 1'b1;
        state_n = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      stage       <= '0;
      stage_en    <= '0;
      req         <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
      instr_count <= '0;
      hold        <= 1'b0;
      auto_q      <= 1'b0;
      pre         <= '0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_n;
      stage       <= stage_n;
      stage_en    <= en_n;
      req         <= req_n;
      halted      <= halted_n;
      error       <= error_n;
      instr_count <= cnt_n;
      hold        <= hold_n;
      auto_q      <= is_auto;
      pre         <= pre_n;
      wait_cnt    <= wait_n;
    end
  end

  assign mem.mem_req = req;

endmodule
